alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one alu instance between NUM_REQ requesters (e.g. execute stage, address-gen, CSR unit).
//  Round-robin arbitration; valid/ready on the request side and the response side.
//  Two-stage pipeline: issue register drives the ALU, response register captures the result.
//  Sits between the requesters and a single combinational alu (types::alu_op_e control).
// PARAMETERS
//  NUM_REQ   2    number of requesters, >=2
//  XLEN      32   operand/result width; must match the alu
//  ID_W      $clog2(NUM_REQ)  requester-index width (derived, not overridable)
// PORTS
//  i_clk          in   1               clock, all state on rising edge
//  i_rst          in   1               synchronous, active-high reset
//  i_req_valid    in   NUM_REQ         per-requester request valid
//  o_req_ready    out  NUM_REQ         per-requester accept (one-hot or zero)
//  i_req_a        in   NUM_REQ x XLEN  operand a per requester
//  i_req_b        in   NUM_REQ x XLEN  operand b per requester
//  i_req_op       in   NUM_REQ x alu_op_e  operation per requester
//  o_rsp_valid    out  1               response valid
//  i_rsp_ready    in   1               response consumer ready
//  o_rsp_id       out  ID_W            index of requester owning the response
//  o_rsp_result   out  XLEN            registered alu result
//  o_rsp_zero     out  1               registered alu zero flag
//  o_alu_a        out  XLEN            to alu.i_a
//  o_alu_b        out  XLEN            to alu.i_b
//  o_alu_ctrl     out  alu_op_e        to alu.i_aluCtrl
//  i_alu_result   in   XLEN            from alu.o_result
//  i_alu_zero     in   1               from alu.o_zero
// BEHAVIOUR
//  Reset: s1_valid=0, s2_valid=0, rr_ptr=0; o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_zero=0,
//   o_req_ready=0, o_alu_a=0, o_alu_b=0, o_alu_ctrl=ENUM_ALU_ADD. Reset mid-transfer drops all in-flight ops.
//  Stages: S1 (issue: a,b,op,id,valid) drives o_alu_*; S2 (response: result,zero,id,valid) drives o_rsp_*.
//  s2_load = s1_valid && (!s2_valid || i_rsp_ready); S2 captures i_alu_result/i_alu_zero/id on s2_load.
//  s2_valid clears when o_rsp_valid && i_rsp_ready && !s2_load.
//  accept_en = !s1_valid || s2_load; S1 loads the granted request when accept_en && |i_req_valid.
//  S1 clears (valid=0) when s2_load and no request is granted that cycle.
//  Arbitration: scan from rr_ptr upward with wrap (NUM_REQ-1 -> 0); first valid wins -> grant (one-hot).
//  o_req_ready = grant & {NUM_REQ{accept_en}} (combinational; depends on i_req_valid; requesters
//   must not make valid depend on ready). Handshake = valid && ready in same cycle.
//  rr_ptr <= granted_index+1 (wrapping) only on an accepted handshake; unchanged otherwise.
//  Fairness: a continuously-valid requester is granted within NUM_REQ accepted handshakes.
//  Latency: handshake at edge N -> o_rsp_valid high after edge N+1 (2-cycle accept-to-response).
//  Throughput: 1 op/cycle while i_rsp_ready=1; with i_rsp_ready=0 pipeline holds 2 ops then
//   o_req_ready drops to 0. S1/S2 contents hold stable while stalled.
//  Idle S1: o_alu_a=0, o_alu_b=0, o_alu_ctrl=ENUM_ALU_ADD (quiet inputs to alu).
//  No combinational path from i_rsp_ready to o_rsp_*; i_rsp_ready -> o_req_ready path is allowed.
//  Requester inputs need only be stable in the handshake cycle; S1 captures them.
// TESTING
//  1 Single: req0 valid a=25 b=10 op=ADD, rsp_ready=1 -> ready0 same cycle; 2 cycles later rsp valid, id=0, result=35, zero=0.
//  2 Contention: req0 and req1 valid every cycle (SUB 25,10 / SUB 7,7) -> grants alternate 0,1,0,1; results 15 (zero=0), 0 (zero=1).
//  3 Backpressure: rsp_ready=0 with req0 streaming -> exactly 2 handshakes then ready=0; result/id held; on rsp_ready=1 drains in order.
//  4 Wrap/fairness: NUM_REQ=3, only req2 then req0 valid -> rr_ptr 0->0 (after req2 wraps to 0), req0 next grant; no req starves over 30 cycles.
//  5 Reset mid-flight: i_rst while S1,S2 valid -> next cycle o_rsp_valid=0, rr_ptr=0, o_alu_ctrl=ENUM_ALU_ADD; no response for dropped ops.
//  6 All ops: each alu_op_e via req1 (e.g. SRA 0x80000000,4 -> 0xF8000000; SLTU 1,2 -> 1) -> result matches alu reference model, id=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational alu among NUM_REQ requesters, issue + response pipeline
package types;
  typedef enum logic [3:0] {
    ENUM_ALU_ADD, ENUM_ALU_SUB, ENUM_ALU_AND, ENUM_ALU_OR, ENUM_ALU_XOR,
    ENUM_ALU_SLL, ENUM_ALU_SRL, ENUM_ALU_SRA, ENUM_ALU_SLT, ENUM_ALU_SLTU
  } alu_op_e;
endpackage

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN = 32,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  i_req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  i_req_b,
  input  types::alu_op_e [NUM_REQ-1:0]  i_req_op,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [XLEN-1:0]               o_rsp_result,
  output logic                          o_rsp_zero,
  output logic [XLEN-1:0]               o_alu_a,
  output logic [XLEN-1:0]               o_alu_b,
  output types::alu_op_e                o_alu_ctrl,
  input  logic [XLEN-1:0]               i_alu_result,
  input  logic                          i_alu_zero
);
  logic s1_valid, s2_valid, s2_zero;
  logic [XLEN-1:0] s1_a, s1_b, s2_result;
  types::alu_op_e s1_op;
  logic [ID_W-1:0] s1_id, s2_id, rr_ptr, gnt_idx, idx;
  logic gnt_any, s2_load, accept_en, hs;
  assign s2_load = s1_valid && (!s2_valid || i_rsp_ready);
  assign accept_en = (!s1_valid || s2_load) && !i_rst;
  assign hs = accept_en && gnt_any;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && i_req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end
  assign o_req_ready = (NUM_REQ'(1) << gnt_idx) & {NUM_REQ{hs}};
  assign o_alu_a = s1_valid ? s1_a : '0;
  assign o_alu_b = s1_valid ? s1_b : '0;
  assign o_alu_ctrl = s1_valid ? s1_op : types::ENUM_ALU_ADD;
  assign o_rsp_valid = s2_valid;
  assign o_rsp_id = s2_id;
  assign o_rsp_result = s2_result;
  assign o_rsp_zero = s2_zero;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_op <= types::ENUM_ALU_ADD;
      s1_id <= '0;
      s2_valid <= 1'b0;
      s2_result <= '0;
      s2_zero <= 1'b0;
      s2_id <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept_en) s1_valid <= gnt_any;
      if (hs) begin
        s1_a <= i_req_a[gnt_idx];
        s1_b <= i_req_b[gnt_idx];
        s1_op <= i_req_op[gnt_idx];
        s1_id <= gnt_idx;
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_result <= i_alu_result;
        s2_zero <= i_alu_zero;
        s2_id <= s1_id;
      end else if (i_rsp_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end
endmodule
